instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute FSM driving every control signal of the 32-bit CPU datapath:
//  register file, IR, status, MDR, MAR, ALU and memory strobes.
//  Sits beside the datapath, reads ir and status, and sequences one instruction at a time.
//  Memory accesses stall on a ready handshake.
// PARAMETERS
//  PC_SEL      4'd13  register-file index of program counter
//  SP_SEL      4'd14  register-file index of stack pointer
//  ALU_PASS_A  4'h0   alu_op code that passes a_bus to result_bus
//  ALU_PASS_B  4'h1   alu_op code that passes b_bus to result_bus
// PORTS
//  clk               in   1   clock, all state changes on rising edge
//  rst               in   1   synchronous, active-high reset
//  ir                in   32  instruction register value
//  status            in   4   {V,N,Z,C} = status[3:0]
//  mem_ready         in   1   memory completes current mem_rd/mem_wr this cycle
//  mem_rd            out  1   memory read strobe; memory drives result_bus when mem_ready
//  mem_wr            out  1   memory write strobe; address = MAR, data = MDR
//  oe_a_reg_file     out  1   reg file drives a_bus from sel_a
//  oe_b_reg_file     out  1   reg file drives b_bus from sel_b
//  ld_a_reg_file     out  1   reg[sel_a] <= result_bus
//  sel_a_reg_file    out  4   A-port register index
//  sel_b_reg_file    out  4   B-port register index
//  count_a_reg_file  out  8   signed increment added to reg[sel_a] at edge (0 = none)
//  count_b_reg_file  out  8   signed increment added to reg[sel_b] at edge (0 = none)
//  ld_ir / ld_status / ld_mdr / ld_mar        out 1  register loads
//  oe_mdr (a_bus) / oe_mar (b_bus) / oe_alu   out 1  bus drives
//  alu_op            out  4   ALU operation
//  halted            out  1   high in HALT state
//  illegal           out  1   one-cycle pulse on undefined opcode
// BEHAVIOUR
//  IR format: [31:28] cond, [27:24] op, [23:20] rd, [19:16] ra, [15:12] rb, [3:0] alu fn.
//  cond: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V. 8-F never; treated as not-taken.
//  Default every cycle: all outputs 0 except as listed; at most one driver per bus.
//  Reset: state <= FETCH_A. All outputs 0 in the reset cycle and the next cycle's
//  registered outputs are FETCH_A values. rst mid-memory-access aborts: strobes drop the same edge.
//  States and per-state outputs:
//   FETCH_A: sel_b=PC_SEL, oe_b, alu_op=PASS_B, oe_alu, ld_mar -> FETCH_M.
//   FETCH_M: mem_rd, ld_mdr gated by mem_ready.
//            Stay while !mem_ready; leave -> FETCH_I.
//   FETCH_I: oe_mdr, PASS_A, oe_alu, ld_ir; sel_a=PC_SEL, count_a=+1 -> DECODE.
//   DECODE:  cond false -> FETCH_A with no side effects; else by op:
//    0 ALU:  EXEC: sel_a=ra oe_a, sel_b=rb oe_b, alu_op=ir[3:0], oe_alu, ld_status,
//            then WB cycle writes rd, same bus setup -> FETCH_A.
//            WB: sel_a=rd is needed for the write, so ALU result is latched into MDR in EXEC
//            and written from MDR via PASS_A in WB. ld_status only in EXEC.
//    1 LD:   MAR<=ra (PASS_A); MEM_RD wait loop; MDR->rd (PASS_A) -> FETCH_A.
//    2 ST:   MAR<=ra; MDR<=rb (PASS_B); MEM_WR held until mem_ready -> FETCH_A.
//    3 B:    sel_b=ra oe_b, PASS_B, oe_alu, ld_a with sel_a=PC_SEL -> FETCH_A.
//    F HALT: -> HALT; stay until rst; halted=1.
//    other:  illegal=1 for one cycle, treated as NOP -> FETCH_A.
//  Latency, zero wait states: ALU 5, B 4, LD 6, ST 6, not-taken 4 cycles.
//  Each mem_ready-low cycle adds exactly one.
//  mem_rd/mem_wr never both high; strobe held constant until the mem_ready cycle.
//  PC increment happens once per fetch, so B targets are absolute.
//  count_* 8-bit two's complement; reg file wraps mod 2^32.
// CONFIGURATION
//  PUSH_POP_EN defined: op 4 PUSH: SP-=1 (count_a=-1, sel_a=SP_SEL), MAR<=SP, MDR<=rb, MEM_WR.
//              op 5 POP:  MAR<=SP, MEM_RD, rd<=MDR, SP+=1.
//              Both conditional like any op.
//  PUSH_POP_EN undefined: ops 4/5 are illegal (pulse illegal, NOP); no SP logic synthesised.
// TESTING
//  rst=1 two cycles, then 0; mem_ready=1 -> cycle 1 after release: sel_b=13, oe_b, ld_mar=1;
//   fetch 0x0_0_1_2_3_005 (ALU r1=r2 op5 r3) -> r1 written 5 cycles after fetch start, ld_status once.
//  LD with mem_ready low for 3 cycles -> mem_rd held 4 cycles, instruction takes 9 cycles,
//   rd = memory data 0xDEADBEEF.
//  Z=0, fetch B cond=1 (0x13000000) -> no reg write, PC only +1, next fetch after 4 cycles.
//  ST r5->[r4] -> mem_wr high with MAR=r4, MDR=r5, mem_rd never asserted; assert no bus contention.
//  op 0x7 -> illegal pulse exactly 1 cycle, PC +1; op 0xF -> halted=1 until rst, no strobes.
//  PUSH_POP_EN: SP=0x100, PUSH r2 then POP r6 -> mem[0xFF]=r2, r6=r2, SP=0x100; without macro: illegal x2.

Source files
------------

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/decode/execute control FSM for the 32-bit CPU datapath.
//               Optional PUSH/POP support is compiled in with PUSH_POP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
    parameter logic [3:0] PC_SEL     = 4'd13,
    parameter logic [3:0] SP_SEL     = 4'd14,
    parameter logic [3:0] ALU_PASS_A = 4'h0,
    parameter logic [3:0] ALU_PASS_B = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic [3:0]  status,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        oe_a_reg_file,
    output logic        oe_b_reg_file,
    output logic        ld_a_reg_file,
    output logic [3:0]  sel_a_reg_file,
    output logic [3:0]  sel_b_reg_file,
    output logic [7:0]  count_a_reg_file,
    output logic [7:0]  count_b_reg_file,
    output logic        ld_ir,
    output logic        ld_status,
    output logic        ld_mdr,
    output logic        ld_mar,
    output logic        oe_mdr,
    output logic        oe_mar,
    output logic        oe_alu,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic        illegal
);

    localparam logic [3:0] S_FETCH_A  = 4'd0;
    localparam logic [3:0] S_FETCH_M  = 4'd1;
    localparam logic [3:0] S_FETCH_I  = 4'd2;
    localparam logic [3:0] S_DECODE   = 4'd3;
    localparam logic [3:0] S_WB       = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_ST_MDR   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_HALT     = 4'd8;
`ifdef PUSH_POP_EN
    localparam logic [3:0] S_PUSH_MAR = 4'd9;
    localparam logic [3:0] OP_PUSH    = 4'h4;
    localparam logic [3:0] OP_POP     = 4'h5;
`endif

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_B    = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [3:0] state_q, state_d;
    logic [3:0] cond_f, op_f, rd_f, ra_f, rb_f, fn_f;
    logic       cond_pass;
    logic       unused_ok;

    assign cond_f = ir[31:28];
    assign op_f   = ir[27:24];
    assign rd_f   = ir[23:20];
    assign ra_f   = ir[19:16];
    assign rb_f   = ir[15:12];
    assign fn_f   = ir[3:0];

    assign unused_ok = ^{ir[11:4], SP_SEL};

    // status = {V,N,Z,C}; codes 8-F never execute
    always_comb begin
        cond_pass = 1'b0;
        case (cond_f)
            4'h0:    cond_pass = 1'b1;
            4'h1:    cond_pass = status[1];
            4'h2:    cond_pass = ~status[1];
            4'h3:    cond_pass = status[0];
            4'h4:    cond_pass = ~status[0];
            4'h5:    cond_pass = status[2];
            4'h6:    cond_pass = ~status[2];
            4'h7:    cond_pass = status[3];
            default: cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH_A: state_d = S_FETCH_M;
            S_FETCH_M: state_d = mem_ready ? S_FETCH_I : S_FETCH_M;
            S_FETCH_I: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH_A;
                if (cond_pass) begin
                    case (op_f)
                        OP_ALU:  state_d = S_WB;
                        OP_LD:   state_d = S_MEM_RD;
                        OP_ST:   state_d = S_ST_MDR;
                        OP_HALT: state_d = S_HALT;
`ifdef PUSH_POP_EN
                        OP_PUSH: state_d = S_PUSH_MAR;
                        OP_POP:  state_d = S_MEM_RD;
`endif
                        default: state_d = S_FETCH_A;
                    endcase
                end
            end
            S_WB:       state_d = S_FETCH_A;
            S_MEM_RD:   state_d = mem_ready ? S_WB : S_MEM_RD;
            S_ST_MDR:   state_d = S_MEM_WR;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH_A : S_MEM_WR;
            S_HALT:     state_d = S_HALT;
`ifdef PUSH_POP_EN
            S_PUSH_MAR: state_d = S_MEM_WR;
`endif
            default:    state_d = S_FETCH_A;
        endcase
    end

    // Outputs are held at zero while rst is high so an in-flight strobe aborts at once.
    always_comb begin
        mem_rd           = 1'b0;
        mem_wr           = 1'b0;
        oe_a_reg_file    = 1'b0;
        oe_b_reg_file    = 1'b0;
        ld_a_reg_file    = 1'b0;
        sel_a_reg_file   = 4'd0;
        sel_b_reg_file   = 4'd0;
        count_a_reg_file = 8'h00;
        count_b_reg_file = 8'h00;
        ld_ir            = 1'b0;
        ld_status        = 1'b0;
        ld_mdr           = 1'b0;
        ld_mar           = 1'b0;
        oe_mdr           = 1'b0;
        oe_mar           = 1'b0;
        oe_alu           = 1'b0;
        alu_op           = 4'h0;
        halted           = 1'b0;
        illegal          = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH_A: begin
                    sel_b_reg_file = PC_SEL;
                    oe_b_reg_file  = 1'b1;
                    alu_op         = ALU_PASS_B;
                    oe_alu         = 1'b1;
                    ld_mar         = 1'b1;
                end
                S_FETCH_M, S_MEM_RD: begin
                    mem_rd = 1'b1;
                    ld_mdr = mem_ready;
                end
                S_FETCH_I: begin
                    oe_mdr           = 1'b1;
                    alu_op           = ALU_PASS_A;
                    oe_alu           = 1'b1;
                    ld_ir            = 1'b1;
                    sel_a_reg_file   = PC_SEL;
                    count_a_reg_file = 8'h01;
                end
                S_DECODE: begin
                    if (cond_pass) begin
                        case (op_f)
                            // Result parks in MDR; the A port is needed for rd in WB.
                            OP_ALU: begin
                                sel_a_reg_file = ra_f;
                                oe_a_reg_file  = 1'b1;
                                sel_b_reg_file = rb_f;
                                oe_b_reg_file  = 1'b1;
                                alu_op         = fn_f;
                                oe_alu         = 1'b1;
                                ld_status      = 1'b1;
                                ld_mdr         = 1'b1;
                            end
                            OP_LD, OP_ST: begin
                                sel_a_reg_file = ra_f;
                                oe_a_reg_file  = 1'b1;
                                alu_op         = ALU_PASS_A;
                                oe_alu         = 1'b1;
                                ld_mar         = 1'b1;
                            end
                            OP_B: begin
                                sel_b_reg_file = ra_f;
                                oe_b_reg_file  = 1'b1;
                                alu_op         = ALU_PASS_B;
                                oe_alu         = 1'b1;
                                sel_a_reg_file = PC_SEL;
                                ld_a_reg_file  = 1'b1;
                            end
                            OP_HALT: begin
                            end
`ifdef PUSH_POP_EN
                            OP_PUSH: begin
                                sel_a_reg_file   = SP_SEL;
                                count_a_reg_file = 8'hFF;
                                sel_b_reg_file   = rb_f;
                                oe_b_reg_file    = 1'b1;
                                alu_op           = ALU_PASS_B;
                                oe_alu           = 1'b1;
                                ld_mdr           = 1'b1;
                            end
                            // MAR takes the old SP while SP increments at the same edge.
                            OP_POP: begin
                                sel_a_reg_file   = SP_SEL;
                                oe_a_reg_file    = 1'b1;
                                alu_op           = ALU_PASS_A;
                                oe_alu           = 1'b1;
                                ld_mar           = 1'b1;
                                count_a_reg_file = 8'h01;
                            end
`endif
                            default: illegal = 1'b1;
                        endcase
                    end
                end
                S_WB: begin
                    oe_mdr         = 1'b1;
                    alu_op         = ALU_PASS_A;
                    oe_alu         = 1'b1;
                    sel_a_reg_file = rd_f;
                    ld_a_reg_file  = 1'b1;
                end
                S_ST_MDR: begin
                    sel_b_reg_file = rb_f;
                    oe_b_reg_file  = 1'b1;
                    alu_op         = ALU_PASS_B;
                    oe_alu         = 1'b1;
                    ld_mdr         = 1'b1;
                end
                S_MEM_WR: mem_wr = 1'b1;
                S_HALT:   halted = 1'b1;
`ifdef PUSH_POP_EN
                S_PUSH_MAR: begin
                    sel_a_reg_file = SP_SEL;
                    oe_a_reg_file  = 1'b1;
                    alu_op         = ALU_PASS_A;
                    oe_alu         = 1'b1;
                    ld_mar         = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
